// File: rtl/image_cell_issuer.sv
// Image-side driver for the cell processor: packs pixel streams into
// cells, waits out the processor latency and streams results back.
module image_cell_issuer #(
  parameter int PIXEL_W  = 8,
  parameter int CELL_N   = 9,
  parameter int OPC_W    = 4,
  parameter int USER_W   = 8,
  parameter int PROC_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [OPC_W-1:0]            cmd_opcode,
  input  logic [USER_W-1:0]           cmd_user,
  input  logic                        cmd_dual,
  input  logic [CNT_W-1:0]            cmd_num_cells,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic [PIXEL_W-1:0]          pix_data,
  output logic [PIXEL_W*CELL_N-1:0]   cellA,
  output logic [PIXEL_W*CELL_N-1:0]   cellB,
  output logic [USER_W-1:0]           userInputA,
  output logic [OPC_W-1:0]            opcode,
  input  logic [PIXEL_W-1:0]          processedPixel,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [PIXEL_W-1:0]          res_data,
  output logic                        res_last,
  output logic                        busy,
  output logic                        done
);

  localparam int PIX_IW = $clog2(CELL_N + 1);
  localparam int LAT_W  = $clog2(PROC_LAT + 1);

  localparam logic [PIX_IW-1:0] PIX_LAST = PIX_IW'(CELL_N - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(PROC_LAT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] OUT    = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  logic [2:0]        state;
  logic              dualQ;
  logic [CNT_W-1:0]  numCells;
  logic [CNT_W-1:0]  cellIdx;
  logic [PIX_IW-1:0] pixIdx;
  logic [LAT_W-1:0]  latCnt;
  logic              isLast;

  assign isLast    = (cellIdx == (numCells - CNT_W'(1)));
  assign cmd_ready = rst & (state == IDLE);
  assign pix_ready = (state == LOAD_A) | (state == LOAD_B);
  assign res_valid = (state == OUT);
  assign res_last  = res_valid & isLast;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // Command sequencing, cell packing, latency wait and result hand-off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dualQ      <= 1'b0;
      numCells   <= '0;
      cellIdx    <= '0;
      pixIdx     <= '0;
      latCnt     <= '0;
      cellA      <= '0;
      cellB      <= '0;
      opcode     <= '0;
      userInputA <= '0;
      res_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            opcode     <= cmd_opcode;
            userInputA <= cmd_user;
            dualQ      <= cmd_dual;
            numCells   <= cmd_num_cells;
            cellIdx    <= '0;
            pixIdx     <= '0;
            if (!cmd_dual) cellB <= '0;
            if (cmd_num_cells == '0) state <= FIN;
            else state <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (pix_valid) begin
            for (int k = 0; k < CELL_N; k++)
              if (pixIdx == PIX_IW'(k))
                cellA[k*PIXEL_W +: PIXEL_W] <= pix_data;
            if (pixIdx == PIX_LAST) begin
              pixIdx <= '0;
              latCnt <= LAT_W'(1);
              state  <= dualQ ? LOAD_B : WAIT;
            end else begin
              pixIdx <= pixIdx + PIX_IW'(1);
            end
          end
        end
        LOAD_B: begin
          if (pix_valid) begin
            for (int k = 0; k < CELL_N; k++)
              if (pixIdx == PIX_IW'(k))
                cellB[k*PIXEL_W +: PIXEL_W] <= pix_data;
            if (pixIdx == PIX_LAST) begin
              pixIdx <= '0;
              latCnt <= LAT_W'(1);
              state  <= WAIT;
            end else begin
              pixIdx <= pixIdx + PIX_IW'(1);
            end
          end
        end
        WAIT: begin
          if (latCnt == LAT_LAST) begin
            res_data <= processedPixel;
            state    <= OUT;
          end else begin
            latCnt <= latCnt + LAT_W'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            if (isLast) begin
              state <= FIN;
            end else begin
              cellIdx <= cellIdx + CNT_W'(1);
              state   <= LOAD_A;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_cell_issuer.sv
// Directed bench for image_cell_issuer with a transaction-level
// scoreboard and a stand-in cell processor.
module tb_image_cell_issuer;

  localparam int PW = 8;
  localparam int CN = 9;
  localparam int OW = 4;
  localparam int UW = 8;
  localparam int PL = 2;
  localparam int CW = 16;
  localparam int CELLW = PW * CN;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OW-1:0]    cmd_opcode;
  logic [UW-1:0]    cmd_user;
  logic             cmd_dual;
  logic [CW-1:0]    cmd_num_cells;
  logic             pix_valid;
  logic             pix_ready;
  logic [PW-1:0]    pix_data;
  logic [CELLW-1:0] cellA;
  logic [CELLW-1:0] cellB;
  logic [UW-1:0]    userInputA;
  logic [OW-1:0]    opcode;
  logic [PW-1:0]    processedPixel;
  logic             res_valid;
  logic             res_ready;
  logic [PW-1:0]    res_data;
  logic             res_last;
  logic             busy;
  logic             done;

  image_cell_issuer #(
    .PIXEL_W(PW), .CELL_N(CN), .OPC_W(OW),
    .USER_W(UW), .PROC_LAT(PL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_user(cmd_user),
    .cmd_dual(cmd_dual), .cmd_num_cells(cmd_num_cells),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data),
    .cellA(cellA), .cellB(cellB),
    .userInputA(userInputA), .opcode(opcode),
    .processedPixel(processedPixel),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fakeProc(
    input logic [CELLW-1:0] a,
    input logic [CELLW-1:0] b,
    input logic [OW-1:0]    op,
    input logic [UW-1:0]    u
  );
    logic [7:0] s;
    s = 8'(op) + u;
    for (int k = 0; k < CN; k++)
      s = s + a[k*PW +: PW] + b[k*PW +: PW];
    return s;
  endfunction

  // stand-in processor: result also encodes the sampling cycle
  assign processedPixel =
    fakeProc(cellA, cellB, opcode, userInputA) ^ cyc[7:0];

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         validCyc;
  } exp_t;

  exp_t expQ[$];
  bit   headSeen = 0;

  logic [CELLW-1:0] mA = '0;
  logic [CELLW-1:0] mB = '0;
  logic [OW-1:0]    mOp;
  logic [UW-1:0]    mUser;
  bit               mDual;
  bit               mPhaseB;
  int               mNum;
  int               mCell;
  int               mPix;
  int               doneExpCyc = -1;
  int               lastHsCyc = 0;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [CELLW-1:0] act,
                     input logic [CELLW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // per-cycle output checks against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      chk(!(res_valid && pix_ready), "res_pix_exclusive",
          CELLW'({res_valid, pix_ready}), '0);
      chk(done == (cyc == doneExpCyc), "done_pulse",
          CELLW'(done), CELLW'(cyc == doneExpCyc));
      if (res_valid) begin
        if (expQ.size() == 0) begin
          chk(1'b0, "unexpected_res", CELLW'(res_data), '0);
        end else begin
          if (!headSeen) begin
            chk(cyc == expQ[0].validCyc, "res_latency",
                CELLW'(cyc), CELLW'(expQ[0].validCyc));
            headSeen = 1;
          end
          chk(res_data == expQ[0].data, "res_data",
              CELLW'(res_data), CELLW'(expQ[0].data));
          chk(res_last == expQ[0].last, "res_last",
              CELLW'(res_last), CELLW'(expQ[0].last));
          if (res_ready) begin
            if (expQ[0].last) doneExpCyc = cyc + 1;
            void'(expQ.pop_front());
            headSeen = 0;
          end
        end
      end
    end
  end

  task automatic modelAccept(input logic [7:0] p, input int c);
    if (!mPhaseB) mA[mPix*PW +: PW] = p;
    else mB[mPix*PW +: PW] = p;
    if (mPix == CN - 1) begin
      mPix = 0;
      if (!mPhaseB && mDual) begin
        mPhaseB = 1;
      end else begin
        mPhaseB = 0;
        expQ.push_back('{fakeProc(mA, mB, mOp, mUser) ^ 8'(c + PL),
                         mCell == mNum - 1, c + PL + 1});
        mCell++;
        lastHsCyc = c;
      end
    end else begin
      mPix++;
    end
  endtask

  task automatic sendCmd(input logic [OW-1:0] op, input logic [UW-1:0] u,
                         input bit dual, input int num);
    bit ok;
    int c;
    ok = 0;
    c = 0;
    cmd_valid = 1'b1;
    cmd_opcode = op;
    cmd_user = u;
    cmd_dual = dual;
    cmd_num_cells = CW'(num);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      c = cyc;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!ok) chk(1'b0, "cmd_timeout", '0, 1);
    mOp = op;
    mUser = u;
    mDual = dual;
    mNum = num;
    mCell = 0;
    mPix = 0;
    mPhaseB = 0;
    if (!dual) mB = '0;
    if (num == 0) doneExpCyc = c + 1;
  endtask

  task automatic sendPix(input logic [7:0] p, input int gap);
    bit ok;
    int c;
    ok = 0;
    c = 0;
    repeat (gap) begin
      pix_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b1;
    pix_data = p;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = pix_ready;
      c = cyc;
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    if (ok) modelAccept(p, c);
    else chk(1'b0, "pix_timeout", CELLW'(p), '0);
  endtask

  task automatic waitIdle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && expQ.size() == 0;
    end
    @(posedge clk);
    #1;
    chk(ok, nm, CELLW'(busy), '0);
  endtask

  task automatic checkAllZero(input string nm);
    logic [CELLW-1:0] v;
    v = CELLW'({opcode, userInputA, res_data, res_valid, res_last,
                done, busy, cmd_ready, pix_ready, |cellA, |cellB});
    chk(v == '0, nm, v, '0);
  endtask

  task automatic waitResValid(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = res_valid;
    end
    if (!ok) chk(1'b0, nm, '0, 1);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_opcode = '0;
    cmd_user = '0;
    cmd_dual = 1'b0;
    cmd_num_cells = '0;
    pix_valid = 1'b0;
    pix_data = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset_state");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single-source, one cell
    sendCmd(4'd3, 8'h10, 1'b0, 1);
    chk(busy == 1'b1, "busy_after_cmd", CELLW'(busy), 1);
    for (int p = 1; p <= 9; p++) sendPix(8'(p), 0);
    chk(cellA == 72'h090807060504030201, "single_cellA",
        cellA, 72'h090807060504030201);
    chk(cellB == '0, "single_cellB", cellB, '0);
    chk(pix_ready == 1'b0, "wait_no_pix", CELLW'(pix_ready), '0);
    waitResValid("single_res_timeout");
    held = 8'h40 ^ 8'(lastHsCyc + 2);
    chk(res_data == held, "single_res_literal",
        CELLW'(res_data), CELLW'(held));
    chk(res_last == 1'b1, "single_res_last", CELLW'(res_last), 1);
    waitIdle("single_idle");
    chk({opcode, userInputA} == 12'h310, "single_op_held",
        CELLW'({opcode, userInputA}), 72'h310);

    // dual-source, two results, continuous pixel stream
    sendCmd(4'd7, 8'h22, 1'b1, 2);
    for (int p = 1; p <= 36; p++) begin
      sendPix(8'(p), 0);
      if (p == 18) begin
        chk(cellA == 72'h090807060504030201, "dual_cellA",
            cellA, 72'h090807060504030201);
        chk(cellB == 72'h1211100f0e0d0c0b0a, "dual_cellB",
            cellB, 72'h1211100f0e0d0c0b0a);
      end
    end
    waitIdle("dual_idle");

    // result backpressure and gappy pixel stream
    sendCmd(4'd2, 8'h05, 1'b0, 2);
    res_ready = 1'b0;
    for (int p = 21; p <= 29; p++) sendPix(8'(p), 1);
    chk(cellA == 72'h1d1c1b1a1918171615, "gap_cellA",
        cellA, 72'h1d1c1b1a1918171615);
    waitResValid("bp_res_timeout");
    held = res_data;
    repeat (5) begin
      @(negedge clk);
      chk(res_data == held && res_valid && !pix_ready, "bp_hold",
          CELLW'({res_valid, pix_ready, res_data}),
          CELLW'({2'b10, held}));
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    for (int p = 31; p <= 39; p++) sendPix(8'(p), 1);
    waitIdle("bp_idle");

    // zero-cell command
    sendCmd(4'd9, 8'h33, 1'b0, 0);
    chk(pix_ready == 1'b0, "zero_no_pix", CELLW'(pix_ready), '0);
    waitIdle("zero_idle");

    // opcode holds until the next command handshake
    sendCmd(4'd1, 8'h01, 1'b0, 0);
    waitIdle("op1_idle");
    repeat (3) begin
      @(negedge clk);
      chk(opcode == 4'd1, "op_hold", CELLW'(opcode), 1);
    end
    @(posedge clk);
    #1;
    sendCmd(4'd5, 8'h02, 1'b0, 0);
    chk(opcode == 4'd5, "op_new", CELLW'(opcode), 5);
    waitIdle("op5_idle");

    // asynchronous reset mid-load
    sendCmd(4'd4, 8'h44, 1'b0, 1);
    for (int p = 1; p <= 4; p++) sendPix(8'(8'hA0 + p), 0);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("reset_async");
    expQ.delete();
    headSeen = 0;
    doneExpCyc = -1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sendCmd(4'd6, 8'h60, 1'b0, 1);
    for (int p = 1; p <= 9; p++) sendPix(8'(8'h30 + p), 0);
    chk(cellA == 72'h393837363534333231, "post_reset_cellA",
        cellA, 72'h393837363534333231);
    waitIdle("post_reset_idle");

    chk(expQ.size() == 0, "queue_empty", CELLW'(expQ.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
